// File: rtl/execute_unit.sv
// Execute stage feeding the data memory: single-cycle ALU plus
// a 32-iteration shift-add multiplier and restoring divider.
module execute_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [WIDTH-1:0] store_data,
    input  logic             write_memory_in,
    input  logic             read_memory_in,
    input  logic             memory_to_register_in,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] address,
    output logic [WIDTH-1:0] writeData,
    output logic             write_memory,
    output logic             read_memory,
    output logic             memory_to_register,
    output logic             zero,
    output logic             valid_out,
    output logic             busy
);

    localparam int CW = $clog2(ITER + 1);
    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] OP_MUL  = 4'd12;
    localparam logic [3:0] OP_DIVU = 4'd13;
    localparam logic [3:0] OP_REMU = 4'd14;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] sd_q;
    logic             wm_q;
    logic             rm_q;
    logic             m2r_q;

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] mul_acc_n;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] div_rem_n;
    logic [WIDTH-1:0] div_q_n;
    logic [WIDTH-1:0] fin_res;
    logic             multi;
    logic             last_iter;

    assign busy = (state != IDLE);

    always_comb begin
        alu_res = '0;
        case (alu_op)
            4'd0:    alu_res = operand_a + operand_b;
            4'd1:    alu_res = operand_a - operand_b;
            4'd2:    alu_res = operand_a & operand_b;
            4'd3:    alu_res = operand_a | operand_b;
            4'd4:    alu_res = operand_a ^ operand_b;
            4'd5:    alu_res = ~(operand_a | operand_b);
            4'd6:    alu_res = {{(WIDTH-1){1'b0}},
                                $signed(operand_a) < $signed(operand_b)};
            4'd7:    alu_res = {{(WIDTH-1){1'b0}}, operand_a < operand_b};
            4'd8:    alu_res = operand_a << operand_b[SW-1:0];
            4'd9:    alu_res = operand_a >> operand_b[SW-1:0];
            4'd10:   alu_res = $signed(operand_a) >>> operand_b[SW-1:0];
            default: alu_res = '0;
        endcase
    end

    // x_q: multiplicand (MUL) or dividend/quotient shift register (DIV)
    always_comb begin
        mul_acc_n = acc_q + (y_q[0] ? x_q : '0);
        rem_sh    = {acc_q, x_q[WIDTH-1]};
        diff      = rem_sh - {1'b0, y_q};
        ge        = ~diff[WIDTH];
        div_rem_n = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        div_q_n   = {x_q[WIDTH-2:0], ge};
        if (state == MUL)
            fin_res = mul_acc_n;
        else if (op_q == OP_REMU)
            fin_res = div_rem_n;
        else
            fin_res = div_q_n;
        multi = (alu_op == OP_MUL) || (alu_op == OP_DIVU)
             || (alu_op == OP_REMU);
        last_iter = (state != IDLE) && (cnt == CW'(ITER - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            cnt                <= '0;
            op_q               <= '0;
            x_q                <= '0;
            y_q                <= '0;
            acc_q              <= '0;
            sd_q               <= '0;
            wm_q               <= 1'b0;
            rm_q               <= 1'b0;
            m2r_q              <= 1'b0;
            result             <= '0;
            address            <= '0;
            writeData          <= '0;
            zero               <= 1'b0;
            valid_out          <= 1'b0;
            write_memory       <= 1'b0;
            read_memory        <= 1'b0;
            memory_to_register <= 1'b0;
        end else begin
            valid_out          <= 1'b0;
            write_memory       <= 1'b0;
            read_memory        <= 1'b0;
            memory_to_register <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && multi) begin
                        op_q  <= alu_op;
                        x_q   <= operand_a;
                        y_q   <= operand_b;
                        acc_q <= '0;
                        cnt   <= '0;
                        sd_q  <= store_data;
                        wm_q  <= write_memory_in;
                        rm_q  <= read_memory_in;
                        m2r_q <= memory_to_register_in;
                        state <= (alu_op == OP_MUL) ? MUL : DIV;
                    end else if (start) begin
                        result             <= alu_res;
                        address            <= alu_res;
                        zero               <= (alu_res == '0);
                        writeData          <= store_data;
                        valid_out          <= 1'b1;
                        write_memory       <= write_memory_in;
                        read_memory        <= read_memory_in;
                        memory_to_register <= memory_to_register_in;
                    end
                end
                MUL: begin
                    x_q   <= x_q << 1;
                    y_q   <= y_q >> 1;
                    acc_q <= mul_acc_n;
                    cnt   <= cnt + 1'b1;
                end
                DIV: begin
                    x_q   <= div_q_n;
                    acc_q <= div_rem_n;
                    cnt   <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
            if (last_iter) begin
                state              <= IDLE;
                result             <= fin_res;
                address            <= fin_res;
                zero               <= (fin_res == '0);
                writeData          <= sd_q;
                valid_out          <= 1'b1;
                write_memory       <= wm_q;
                read_memory        <= rm_q;
                memory_to_register <= m2r_q;
            end
        end
    end

endmodule

// File: tb/tb_execute_unit.sv
// Scoreboard bench for execute_unit: driver pushes reference results,
// a negedge monitor pops and compares on every valid_out pulse.
module tb_execute_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  alu_op = '0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic [31:0] store_data = '0;
    logic        write_memory_in = 1'b0;
    logic        read_memory_in = 1'b0;
    logic        memory_to_register_in = 1'b0;
    logic [31:0] result;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        write_memory;
    logic        read_memory;
    logic        memory_to_register;
    logic        zero;
    logic        valid_out;
    logic        busy;

    execute_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .start                 (start),
        .alu_op                (alu_op),
        .operand_a             (operand_a),
        .operand_b             (operand_b),
        .store_data            (store_data),
        .write_memory_in       (write_memory_in),
        .read_memory_in        (read_memory_in),
        .memory_to_register_in (memory_to_register_in),
        .result                (result),
        .address               (address),
        .writeData             (writeData),
        .write_memory          (write_memory),
        .read_memory           (read_memory),
        .memory_to_register    (memory_to_register),
        .zero                  (zero),
        .valid_out             (valid_out),
        .busy                  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [31:0] wd;
        logic        wm;
        logic        rm;
        logic        m2r;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] last_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        logic [4:0]  sh;
        sh = b[4:0];
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = ~(a | b);
            4'd6:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:    r = (a < b) ? 32'd1 : 32'd0;
            4'd8:    r = a << sh;
            4'd9:    r = a >> sh;
            4'd10:   r = $signed(a) >>> sh;
            4'd12:   r = a * b;
            4'd13:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd14:   r = (b == 0) ? a : a % b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last_res = '0;
        end else begin
            if (busy && valid_out)
                chk("busy_and_valid", 32'd1, 32'd0);
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", result, e.res);
                    chk("address", address, e.res);
                    chk("writeData", writeData, e.wd);
                    chk("zero", {31'd0, zero}, {31'd0, e.res == 0});
                    chk("write_memory", {31'd0, write_memory}, {31'd0, e.wm});
                    chk("read_memory", {31'd0, read_memory}, {31'd0, e.rm});
                    chk("mem_to_reg", {31'd0, memory_to_register},
                        {31'd0, e.m2r});
                    chk("latency", cyc, e.cyc);
                end
                last_res = result;
            end else begin
                chk("strobes_idle",
                    {29'd0, write_memory, read_memory, memory_to_register},
                    32'd0);
                chk("result_hold", result, last_res);
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] sd,
                         input logic wm, input logic rm, input logic m2r);
        exp_t e;
        int   n;
        int   lat;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("busy_timeout", 32'd1, 32'd0);
        alu_op = op;
        operand_a = a;
        operand_b = b;
        store_data = sd;
        write_memory_in = wm;
        read_memory_in = rm;
        memory_to_register_in = m2r;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = (op == 4'd12 || op == 4'd13 || op == 4'd14) ? 33 : 1;
        e.res = model(op, a, b);
        e.wd = sd;
        e.wm = wm;
        e.rm = rm;
        e.m2r = m2r;
        e.cyc = cyc + lat - 1;
        exp_q.push_back(e);
        operand_a = $urandom;
        operand_b = $urandom;
        store_data = $urandom;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_result"}, result, 32'd0);
        chk({tag, "_address"}, address, 32'd0);
        chk({tag, "_writeData"}, writeData, 32'd0);
        chk({tag, "_flags"},
            {26'd0, zero, valid_out, busy, write_memory, read_memory,
             memory_to_register}, 32'd0);
    endtask

    initial begin
        int bcount;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;

        issue(4'd0, 32'd5, 32'd7, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        issue(4'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0);
        issue(4'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0);
        issue(4'd1, 32'd9, 32'd9, 32'd0, 1'b0, 1'b0, 1'b0);
        issue(4'd10, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 1'b0, 1'b0);
        issue(4'd0, 32'h10, 32'd4, 32'd0, 1'b0, 1'b1, 1'b1);
        issue(4'd11, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0, 1'b0);
        issue(4'd15, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0, 1'b0);

        // MUL with a stray start ten cycles in
        issue(4'd12, 32'h0000_FFFF, 32'h0001_0001, 32'h55, 1'b0, 1'b0, 1'b1);
        bcount = 0;
        while (busy && bcount < 100) begin
            @(negedge clk);
            if (busy) bcount++;
            if (bcount == 9) begin
                alu_op = 4'd0;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("mul_busy_cycles", bcount, 32'd32);

        issue(4'd13, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0);
        issue(4'd14, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0);
        issue(4'd13, 32'h1234, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        issue(4'd14, 32'h1234, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

        // reset in the middle of a DIVU aborts it silently
        issue(4'd13, 32'd1000, 32'd3, 32'd0, 1'b0, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        exp_q.delete();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_cleared("midop_reset");
        issue(4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 250; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 4'($urandom_range(0, 15));
            a = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 40));
                2:       b = a;
                default: b = $urandom;
            endcase
            issue(op, a, b, $urandom, 1'($urandom), 1'($urandom),
                  1'($urandom));
        end

        bcount = 0;
        while (exp_q.size() != 0 && bcount < 200) begin
            @(negedge clk);
            bcount++;
        end
        repeat (3) @(negedge clk);
        chk("drain_pending", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/execute_unit.md
Name: execute_unit

Overview:
Execute stage directly upstream of the data memory. It accepts decoded operands and memory control bits, and computes the ALU result, which doubles as the load/store address. It drives result, address, writeData and the memory control strobes into the memory stage. Single-cycle ALU ops finish in 1 cycle; MUL/DIVU/REMU run a 32-iteration sequential datapath with a busy handshake.

Parameters:
WIDTH, 32, operand/result width (design verified only at 32)
ITER, 32, iterations for MUL/DIVU/REMU (must equal WIDTH)

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous active-high reset
start  input  1  operation request; sampled only when busy=0
alu_op  input  4  operation select (encoding below)
operand_a  input  32  first operand / base / shift source
operand_b  input  32  second operand / offset / shift amount
store_data  input  32  data for stores, passed to writeData
write_memory_in  input  1  store request, travels with op
read_memory_in  input  1  load request, travels with op
memory_to_register_in  input  1  writeback-select, travels with op
result  output  32  operation result
address  output  32  memory address (= result)
writeData  output  32  registered store_data
write_memory  output  1  store strobe, 1-cycle pulse with valid_out
read_memory  output  1  load strobe, 1-cycle pulse with valid_out
memory_to_register  output  1  pulses with valid_out
zero  output  1  result==0, updated with result
valid_out  output  1  result valid, 1-cycle pulse
busy  output  1  multi-cycle op in progress

Behaviour:
- Reset: all outputs 0, FSM to IDLE, iteration counter 0. Reset mid-operation aborts the op; no valid_out is produced for it.
- alu_op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR
  - 6 SLT (signed), 7 SLTU
  - 8 SLL, 9 SRL, 10 SRA: operand_a shifted by operand_b[4:0]
  - 12 MUL: low 32 bits, unsigned shift-add
  - 13 DIVU: quotient, restoring division
  - 14 REMU: remainder, restoring division
  - 11 and 15: result 0
- Arithmetic: ADD/SUB wrap mod 2^32, with no overflow flag or trap.
- FSM states: IDLE, MUL, DIV.
  - IDLE with start=1 and a single-cycle op: result registered at that edge (E0). valid_out=1 for the following cycle. Latency 1.
  - IDLE with start=1 and op 12/13/14: operands and control bits are latched at E0, counter cleared, go to MUL or DIV. busy=1 from the cycle after E0.
  - MUL/DIV: one iteration per edge, E1..E32. At E32, result is registered, state returns to IDLE, busy falls to 0, and valid_out=1 for the next cycle. Latency 33 cycles.
- start while busy=1 is ignored; there is no queueing. Upstream must stall on busy. The first accepted start is at the first edge where busy=0.
- Divide by zero follows naturally from restoring division: DIVU gives 0xFFFFFFFF, REMU gives operand_a. Still 33 cycles, no exception.
- Control bits and store_data are latched at acceptance and presented with the result.
- write_memory, read_memory and memory_to_register are 1 only while valid_out=1, and 0 otherwise. This guarantees the memory writes exactly once per store.
- result, address, writeData and zero hold their last values between valid pulses.
- address = result in all cases. A store/load uses alu_op=ADD with base in operand_a and offset in operand_b.
- busy = (state != IDLE). busy and valid_out are never both 1.

Test Plan:
- ADD a=5, b=7, write_memory_in=1, store_data=0xDEADBEEF → one cycle later: result=address=12, writeData=0xDEADBEEF, write_memory=1 for exactly 1 cycle, valid_out=1 for 1 cycle, zero=0.
- SLT a=0xFFFFFFFF, b=1 → result 1. SLTU same operands → result 0. SUB 9−9 → result 0, zero=1. SRA 0x80000000 by 4 → 0xF8000000.
- MUL a=0x0000FFFF, b=0x00010001 → busy=1 for 32 cycles, valid_out 33 cycles after start, result=0xFFFFFFFF. A start asserted at cycle 10 of the op is ignored (no extra valid_out).
- DIVU 100/7 → 14. REMU 100/7 → 2. DIVU 0x1234/0 → 0xFFFFFFFF. REMU 0x1234/0 → 0x1234. Each has 33-cycle latency.
- LW flow: ADD a=0x10, b=4, read_memory_in=1, memory_to_register_in=1 → address=0x14, read_memory and memory_to_register pulse 1 cycle, write_memory stays 0.
- rst asserted at iteration 10 of DIVU → next cycle busy=0, valid_out=0, all outputs 0. A following ADD 1+1 completes normally with result 2.
